multi_digit_decimal_adder: RTL

MULTI_DIGIT_DECIMAL_ADDER -- requirements
Module: multi_digit_decimal_adder

---
 rtl/mda_pkg.sv | 51 +++++
 rtl/bcd_digit_alu.sv | 41 ++++
 rtl/multi_digit_decimal_adder.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mda_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mda_pkg
// Description : Shared types and PS/2 scan-code constants for the
//               multi-digit decimal adder.
// Revision    : 1.0 - initial release
// ============================================================================
package mda_pkg;

    typedef enum logic [1:0] {
        ST_ENTER_A = 2'd0,
        ST_ENTER_B = 2'd1,
        ST_CALC    = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

    localparam logic [7:0] C_KEY_BKSP     = 8'h66;
    localparam logic [7:0] C_KEY_PLUS     = 8'h79;
    localparam logic [7:0] C_KEY_MINUS_KP = 8'h7B;
    localparam logic [7:0] C_KEY_MINUS_MR = 8'h4E;
    localparam logic [7:0] C_KEY_ENTER    = 8'h5A;
    localparam logic [7:0] C_KEY_ESC      = 8'h76;

    localparam logic [7:0] C_KP_DIGIT [10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B,
                                               8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};
    localparam logic [7:0] C_MR_DIGIT [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                               8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

    // Returns {hit, digit}; extended (E0) codes never map to a digit.
    function automatic logic [4:0] decode_digit(input logic [8:0] code,
                                                input logic       main_row_en);
        logic [4:0] r;
        r = 5'd0;
        if (!code[8]) begin
            for (int i = 0; i < 10; i++) begin
                if (code[7:0] == C_KP_DIGIT[i] ||
                    (main_row_en && code[7:0] == C_MR_DIGIT[i])) begin
                    r = {1'b1, 4'(i)};
                end
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_alu.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_alu
// Description : Single BCD digit add/subtract step with carry/borrow chain.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_alu
    import mda_pkg::*;
(
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    input  op_t        i_op,
    output logic [3:0] o_d,
    output logic       o_cout
);

    logic [4:0] w_sum;
    logic [4:0] w_diff;

    always_comb begin
        w_sum  = {1'b0, i_a} + {1'b0, i_b} + {4'd0, i_cin};
        w_diff = {1'b0, i_a} - {1'b0, i_b} - {4'd0, i_cin};
        o_d    = w_sum[3:0];
        o_cout = 1'b0;
        if (i_op == OP_SUB) begin
            // Negative two's-complement nibble plus ten yields the borrowed digit.
            if (w_diff[4]) begin
                o_d    = w_diff[3:0] + 4'd10;
                o_cout = 1'b1;
            end else begin
                o_d    = w_diff[3:0];
            end
        end else if (w_sum > 5'd9) begin
            o_d    = w_sum[3:0] + 4'd6;
            o_cout = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/multi_digit_decimal_adder.sv
`default_nettype none
// ============================================================================
// Module      : multi_digit_decimal_adder
// Description : PS/2 keyed BCD calculator: enter A, operator, B, Enter; the
//               result is computed one digit per cycle. Define MDA_SUBTRACT_EN
//               to add the minus keys and the subtraction datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_digit_decimal_adder
    import mda_pkg::*;
#(
    parameter int DIGITS      = 2,
    parameter int MAIN_ROW_EN = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    key_pulse,
    input  logic [8:0]              key_code,
    output logic [4*DIGITS-1:0]     a_bcd,
    output logic [4*DIGITS-1:0]     b_bcd,
    output logic [4*(DIGITS+1)-1:0] result_bcd,
    output logic                    result_neg,
    output logic                    result_valid,
    output logic [1:0]              state
);

    localparam int         W        = 4 * DIGITS;
    localparam int         RW       = 4 * (DIGITS + 1);
    localparam logic [2:0] C_DIGITS = 3'(DIGITS);

    state_t        r_state;
    op_t           r_op;
    logic [W-1:0]  r_a, r_b, r_x, r_y;
    logic [RW-1:0] r_result;
    logic [2:0]    r_cnt_a, r_cnt_b, r_idx;
    logic          r_carry, r_valid;

    logic [4:0] w_dig;
    logic       w_digit, w_esc, w_bksp, w_plus, w_minus, w_enter;
    logic       w_start, w_done_digit, w_swap;
    logic [3:0] w_alu_d;
    logic       w_alu_cout;

    assign w_dig        = decode_digit(key_code, MAIN_ROW_EN != 0);
    assign w_digit      = key_pulse && w_dig[4];
    assign w_esc        = key_pulse && (key_code == {1'b0, C_KEY_ESC});
    assign w_bksp       = key_pulse && (key_code == {1'b0, C_KEY_BKSP});
    assign w_plus       = key_pulse && (key_code == {1'b0, C_KEY_PLUS});
    assign w_enter      = key_pulse && (key_code[7:0] == C_KEY_ENTER);
    assign w_start      = (r_state == ST_ENTER_B) && w_enter;
    assign w_done_digit = (r_state == ST_DONE) && w_digit;

    function automatic logic [W-1:0] push_digit(input logic [W-1:0] v, input logic [3:0] d);
        logic [W-1:0] t;
        t      = v << 4;
        t[3:0] = d;
        return t;
    endfunction

`ifdef MDA_SUBTRACT_EN
    logic r_neg;

    assign w_minus = key_pulse && ((key_code == {1'b0, C_KEY_MINUS_KP}) ||
                                   (key_code == {1'b0, C_KEY_MINUS_MR}));
    // Subtract the smaller operand from the larger so the chain yields |A-B|.
    assign w_swap  = (r_op == OP_SUB) && (r_a < r_b);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_neg <= 1'b0;
        end else if (w_esc || w_done_digit) begin
            r_neg <= 1'b0;
        end else if (w_start) begin
            r_neg <= w_swap;
        end
    end

    assign result_neg = r_neg;
`else
    assign w_minus    = 1'b0;
    assign w_swap     = 1'b0;
    assign result_neg = 1'b0;
`endif

    bcd_digit_alu u_alu (
        .i_a    (r_x[3:0]),
        .i_b    (r_y[3:0]),
        .i_cin  (r_carry),
        .i_op   (r_op),
        .o_d    (w_alu_d),
        .o_cout (w_alu_cout)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_ENTER_A;
            r_op     <= OP_ADD;
            r_a      <= '0;
            r_b      <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_result <= '0;
            r_cnt_a  <= 3'd0;
            r_cnt_b  <= 3'd0;
            r_idx    <= 3'd0;
            r_carry  <= 1'b0;
            r_valid  <= 1'b0;
        end else if (w_esc) begin
            r_state  <= ST_ENTER_A;
            r_op     <= OP_ADD;
            r_a      <= '0;
            r_b      <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_result <= '0;
            r_cnt_a  <= 3'd0;
            r_cnt_b  <= 3'd0;
            r_idx    <= 3'd0;
            r_carry  <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            case (r_state)
                ST_ENTER_A: begin
                    if (w_digit) begin
                        if (r_cnt_a < C_DIGITS) begin
                            r_a     <= push_digit(r_a, w_dig[3:0]);
                            r_cnt_a <= r_cnt_a + 3'd1;
                        end
                    end else if (w_bksp) begin
                        r_a <= r_a >> 4;
                        if (r_cnt_a != 3'd0) r_cnt_a <= r_cnt_a - 3'd1;
                    end else if (w_plus) begin
                        r_op    <= OP_ADD;
                        r_state <= ST_ENTER_B;
                    end else if (w_minus) begin
                        r_op    <= OP_SUB;
                        r_state <= ST_ENTER_B;
                    end
                end
                ST_ENTER_B: begin
                    if (w_digit) begin
                        if (r_cnt_b < C_DIGITS) begin
                            r_b     <= push_digit(r_b, w_dig[3:0]);
                            r_cnt_b <= r_cnt_b + 3'd1;
                        end
                    end else if (w_bksp) begin
                        r_b <= r_b >> 4;
                        if (r_cnt_b != 3'd0) r_cnt_b <= r_cnt_b - 3'd1;
                    end else if (w_start) begin
                        r_x      <= w_swap ? r_b : r_a;
                        r_y      <= w_swap ? r_a : r_b;
                        r_idx    <= 3'd0;
                        r_carry  <= 1'b0;
                        r_result <= '0;
                        r_valid  <= 1'b0;
                        r_state  <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    // Operands drain LSB first; result digits enter from the top.
                    r_x      <= r_x >> 4;
                    r_y      <= r_y >> 4;
                    r_carry  <= w_alu_cout;
                    r_result <= {w_alu_d, r_result[RW-1:4]};
                    r_idx    <= r_idx + 3'd1;
                    if (r_idx == C_DIGITS) begin
                        r_state <= ST_DONE;
                        r_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (w_digit) begin
                        r_a      <= W'(w_dig[3:0]);
                        r_b      <= '0;
                        r_result <= '0;
                        r_valid  <= 1'b0;
                        r_cnt_a  <= 3'd1;
                        r_cnt_b  <= 3'd0;
                        r_op     <= OP_ADD;
                        r_state  <= ST_ENTER_A;
                    end
                end
            endcase
        end
    end

    assign a_bcd        = r_a;
    assign b_bcd        = r_b;
    assign result_bcd   = r_result;
    assign result_valid = r_valid;
    assign state        = r_state;

endmodule
`default_nettype wire
